// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-write bundle between the program source, the
// loader and the pipeline instruction memory.
interface imem_loader_if #(
   parameter int MAX_WORDS = 256
);
   localparam int CW = $clog2(MAX_WORDS + 1);

   logic          load_req;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          rx_last;
   logic          rx_ready;
   logic [31:0]   address;
   logic [31:0]   instruction;
   logic          load_we;
   logic          start;
   logic [CW-1:0] word_count;
   logic          busy;
   logic          error;

   modport master (
      output load_req, rx_valid, rx_byte, rx_last,
      input  rx_ready, address, instruction, load_we, start, word_count, busy, error
   );

   modport slave (
      input  load_req, rx_valid, rx_byte, rx_last,
      output rx_ready, address, instruction, load_we, start, word_count, busy, error
   );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial program loader: packs bytes little-endian into 32-bit words,
// strobes them into instruction memory, then releases the pipeline via start.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MAX_WORDS   = 256,
   parameter int          START_DELAY = 2
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int DW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_ARM  = 3'd2;
   localparam logic [2:0] ST_RUN  = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   logic [2:0]    r_state;
   logic [1:0]    r_idx;
   logic [31:0]   r_partial;
   logic [CW-1:0] r_word_count;
   logic [DW-1:0] r_dly;
   logic          r_rx_ready;
   logic [31:0]   r_address;
   logic [31:0]   r_instruction;
   logic          r_load_we;
   logic          r_start;
   logic          r_busy;
   logic          r_error;

   logic          w_hs;
   logic          w_done;
   logic          w_full;
   logic [31:0]   w_word;
   logic [31:0]   w_addr;

   // Lanes above the current index are already zero, so a short final word
   // comes out zero-padded without extra masking.
   assign w_hs   = (r_state == ST_LOAD) && r_rx_ready && bus.rx_valid;
   assign w_word = r_partial | (32'(bus.rx_byte) << {r_idx, 3'b000});
   assign w_done = w_hs && ((r_idx == 2'd3) || bus.rx_last);
   assign w_full = (r_word_count == CW'(MAX_WORDS));
   assign w_addr = BASE_ADDR + (32'(r_word_count) << 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_partial     <= '0;
         r_word_count  <= '0;
         r_dly         <= '0;
         r_rx_ready    <= 1'b0;
         r_address     <= '0;
         r_instruction <= '0;
         r_load_we     <= 1'b0;
         r_start       <= 1'b0;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_load_we <= 1'b0;
         // load_req wins over any byte handshake in the same cycle
         if (bus.load_req) begin
            r_state      <= ST_LOAD;
            r_idx        <= '0;
            r_partial    <= '0;
            r_word_count <= '0;
            r_error      <= 1'b0;
            r_start      <= 1'b0;
            r_rx_ready   <= 1'b1;
            r_busy       <= 1'b1;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  if (w_hs) begin
                     r_idx     <= r_idx + 2'd1;
                     r_partial <= w_word;
                     if (w_done) begin
                        r_idx     <= '0;
                        r_partial <= '0;
                        if (w_full) begin
                           r_error    <= 1'b1;
                           r_state    <= ST_ERR;
                           r_rx_ready <= 1'b0;
                           r_busy     <= 1'b0;
                        end else begin
                           r_instruction <= w_word;
                           r_address     <= w_addr;
                           r_load_we     <= 1'b1;
                           r_word_count  <= r_word_count + CW'(1);
                           if (bus.rx_last) begin
                              r_state    <= ST_ARM;
                              r_rx_ready <= 1'b0;
                              r_dly      <= '0;
                           end
                        end
                     end
                  end
               end
               // first ARM cycle coincides with the final load_we cycle
               ST_ARM: begin
                  if (r_dly == DW'(START_DELAY)) begin
                     r_state <= ST_RUN;
                     r_start <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_dly <= r_dly + DW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_ready    = r_rx_ready;
   assign bus.address     = r_address;
   assign bus.instruction = r_instruction;
   assign bus.load_we     = r_load_we;
   assign bus.start       = r_start;
   assign bus.word_count  = r_word_count;
   assign bus.busy        = r_busy;
   assign bus.error       = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: dut_a uses defaults, dut_b is a two-word,
// zero-delay instance for overflow and minimum start latency.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic       sel = 1'b0;
   logic       tb_load_req = 1'b0;
   logic       tb_valid = 1'b0;
   logic [7:0] tb_byte = 8'h00;
   logic       tb_last = 1'b0;

   imem_loader_if #(.MAX_WORDS(256)) bus_a ();
   imem_loader_if #(.MAX_WORDS(2))   bus_b ();

   assign bus_a.load_req = tb_load_req & ~sel;
   assign bus_a.rx_valid = tb_valid & ~sel;
   assign bus_a.rx_byte  = tb_byte;
   assign bus_a.rx_last  = tb_last;
   assign bus_b.load_req = tb_load_req & sel;
   assign bus_b.rx_valid = tb_valid & sel;
   assign bus_b.rx_byte  = tb_byte;
   assign bus_b.rx_last  = tb_last;

   imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .START_DELAY(2))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(2), .START_DELAY(0))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   logic w_rdy, w_start, w_busy, w_err;
   int   w_cnt;
   assign w_rdy   = sel ? bus_b.rx_ready : bus_a.rx_ready;
   assign w_start = sel ? bus_b.start    : bus_a.start;
   assign w_busy  = sel ? bus_b.busy     : bus_a.busy;
   assign w_err   = sel ? bus_b.error    : bus_a.error;
   assign w_cnt   = sel ? int'(bus_b.word_count) : int'(bus_a.word_count);

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   last_we_a = 0;
   int   last_we_b = 0;

   always @(negedge clk) begin
      if (bus_a.load_we) begin
         exp_t e;
         last_we_a = cyc;
         n_cmp++;
         if (q_a.size() == 0) begin
            n_err++;
            $display("FAIL a_unexpected_write got a=%h d=%h", bus_a.address, bus_a.instruction);
         end else begin
            e = q_a.pop_front();
            if (bus_a.address !== e.a || bus_a.instruction !== e.d || int'(bus_a.word_count) != e.c) begin
               n_err++;
               $display("FAIL a_write got a=%h d=%h c=%0d exp a=%h d=%h c=%0d",
                        bus_a.address, bus_a.instruction, bus_a.word_count, e.a, e.d, e.c);
            end
         end
      end
      if (bus_b.load_we) begin
         exp_t e;
         last_we_b = cyc;
         n_cmp++;
         if (q_b.size() == 0) begin
            n_err++;
            $display("FAIL b_unexpected_write got a=%h d=%h", bus_b.address, bus_b.instruction);
         end else begin
            e = q_b.pop_front();
            if (bus_b.address !== e.a || bus_b.instruction !== e.d || int'(bus_b.word_count) != e.c) begin
               n_err++;
               $display("FAIL b_write got a=%h d=%h c=%0d exp a=%h d=%h c=%0d",
                        bus_b.address, bus_b.instruction, bus_b.word_count, e.a, e.d, e.c);
            end
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] d, input int c);
      exp_t e;
      e.a = a; e.d = d; e.c = c;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   // Entered and left #1 after a rising edge.
   task automatic pulse_req();
      tb_load_req = 1'b1;
      @(posedge clk); #1;
      tb_load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      bit hs;
      hs = 1'b0;
      tb_valid = 1'b1; tb_byte = b; tb_last = last;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge clk); hs = w_rdy;
         @(posedge clk); #1;
      end
      tb_valid = 1'b0; tb_last = 1'b0;
      if (!hs) begin
         n_cmp++; n_err++;
         $display("FAIL send_byte_timeout byte=%h rx_ready never seen", b);
      end
   endtask

   task automatic wait_start(input int exp_gap, input string name);
      bit seen;
      int gap;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk); seen = w_start;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s_start_timeout start=0 required 1", name);
      end else begin
         gap = cyc - (sel ? last_we_b : last_we_a);
         n_cmp++;
         if (gap != exp_gap) begin
            n_err++;
            $display("FAIL %s_start_latency got %0d required %0d", name, gap, exp_gap);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bit any_rdy;
      @(negedge clk);
      n_cmp++;
      if ({bus_a.load_we, bus_a.start, bus_a.busy, bus_a.error, bus_a.rx_ready} !== 5'b0 ||
          bus_a.address !== 32'h0 || bus_a.instruction !== 32'h0 || bus_a.word_count !== '0) begin
         n_err++;
         $display("FAIL reset_values got we/st/bz/er/rdy=%b a=%h d=%h c=%0d required all 0",
                  {bus_a.load_we, bus_a.start, bus_a.busy, bus_a.error, bus_a.rx_ready},
                  bus_a.address, bus_a.instruction, bus_a.word_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      any_rdy = 1'b0;
      repeat (3) begin @(negedge clk); any_rdy |= w_rdy; end
      n_cmp++;
      if (any_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_rx_ready got 1 required 0");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      pulse_req();
      n_cmp++;
      if (w_rdy !== 1'b1 || w_busy !== 1'b1) begin
         n_err++;
         $display("FAIL single_ready got rdy=%b busy=%b required 1 1", w_rdy, w_busy);
      end
      push(32'h0, 32'h0000_0013, 1);
      send_byte(8'h13, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b1);
      wait_start(3, "single");
      n_cmp++;
      if (w_cnt != 1 || w_busy !== 1'b0 || w_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL single_run got cnt=%0d busy=%b rdy=%b required 1 0 0", w_cnt, w_busy, w_rdy);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus_a.load_we, bus_a.start, bus_a.busy, bus_a.error, bus_a.rx_ready} !== 5'b0 ||
          bus_a.address !== 32'h0 || bus_a.instruction !== 32'h0 || bus_a.word_count !== '0) begin
         n_err++;
         $display("FAIL async_reset got we/st/bz/er/rdy=%b a=%h d=%h c=%0d required all 0",
                  {bus_a.load_we, bus_a.start, bus_a.busy, bus_a.error, bus_a.rx_ready},
                  bus_a.address, bus_a.instruction, bus_a.word_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (w_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_rx_ready got %b required 0", w_rdy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_partial_word();
      pulse_req();
      push(32'h0, 32'hDEAD_BEEF, 1);
      push(32'h4, 32'h0000_1234, 2);
      send_byte(8'hEF, 1'b0);
      send_byte(8'hBE, 1'b0);
      send_byte(8'hAD, 1'b0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b1);
      wait_start(3, "partial");
   endtask

   task automatic test_gaps();
      pulse_req();
      push(32'h0, 32'h0403_0201, 1);
      push(32'h4, 32'h0807_0605, 2);
      for (int i = 1; i <= 8; i++) begin
         send_byte(8'(i), i == 8);
         if (i < 8) begin @(posedge clk); #1; end
      end
      wait_start(3, "gaps");
      n_cmp++;
      if (w_cnt != 2) begin
         n_err++;
         $display("FAIL gaps_count got %0d required 2", w_cnt);
      end
   endtask

   task automatic test_reload_run();
      n_cmp++;
      if (w_start !== 1'b1) begin
         n_err++;
         $display("FAIL reload_pre_start got %b required 1", w_start);
      end
      pulse_req();
      n_cmp++;
      if (w_start !== 1'b0 || w_cnt != 0 || w_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL reload_clear got st=%b cnt=%0d rdy=%b required 0 0 1", w_start, w_cnt, w_rdy);
      end
      push(32'h0, 32'hAABB_CCDD, 1);
      send_byte(8'hDD, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hAA, 1'b1);
      wait_start(3, "reload");
   endtask

   task automatic test_restart_load();
      pulse_req();
      push(32'h0, 32'h4433_2211, 1);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      tb_load_req = 1'b1; tb_valid = 1'b1; tb_byte = 8'h99;
      @(posedge clk); #1;
      tb_load_req = 1'b0; tb_valid = 1'b0;
      n_cmp++;
      if (w_cnt != 0 || w_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL restart_clear got cnt=%0d rdy=%b required 0 1", w_cnt, w_rdy);
      end
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      wait_start(3, "restart");
   endtask

   task automatic test_overflow();
      bit any_start;
      sel = 1'b1;
      @(posedge clk); #1;
      pulse_req();
      push(32'h0, 32'h0403_0201, 1);
      push(32'h4, 32'h0807_0605, 2);
      for (int i = 1; i <= 12; i++) send_byte(8'(i), i == 12);
      n_cmp++;
      if (w_err !== 1'b1 || w_rdy !== 1'b0 || w_busy !== 1'b0 || w_cnt != 2) begin
         n_err++;
         $display("FAIL overflow_state got err=%b rdy=%b busy=%b cnt=%0d required 1 0 0 2",
                  w_err, w_rdy, w_busy, w_cnt);
      end
      any_start = 1'b0;
      repeat (6) begin @(negedge clk); any_start |= w_start; end
      n_cmp++;
      if (any_start !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_start got 1 required 0");
      end
      @(posedge clk); #1;
      pulse_req();
      n_cmp++;
      if (w_err !== 1'b0 || w_rdy !== 1'b1 || w_cnt != 0) begin
         n_err++;
         $display("FAIL overflow_clear got err=%b rdy=%b cnt=%0d required 0 1 0", w_err, w_rdy, w_cnt);
      end
      push(32'h0, 32'h0000_00AB, 1);
      send_byte(8'hAB, 1'b1);
      wait_start(1, "zero_delay");
      sel = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_single_word();
      test_async_reset();
      test_partial_word();
      test_gaps();
      test_reload_run();
      test_restart_load();
      test_overflow();
      repeat (4) @(posedge clk);
      n_cmp++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_err++;
         $display("FAIL missing_writes got %0d/%0d pending required 0/0", q_a.size(), q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial instruction loader that sits directly upstream of the RISC-V pipeline top. It accepts a program as a stream of bytes over a valid/ready handshake and assembles them little-endian into 32-bit words. Each word is presented on `address`/`instruction` with a one-cycle write strobe. After the last byte it holds the pipeline in load mode for a programmable delay, then raises `start` to release execution.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, 256: instruction memory capacity in words; a completed word beyond this is an overflow.
- `START_DELAY`, 2: idle cycles between the final word write and `start` rising.

Ports:
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `load_req`  in  1  — one-cycle pulse; begins or restarts a load.
- `rx_valid`  in  1  — byte valid from the byte source.
- `rx_byte`  in  8  — program byte.
- `rx_last`  in  1  — qualifies the final byte of the program; sampled only on a handshake.
- `rx_ready`  out  1  — loader can accept a byte.
- `address`  out  32  — instruction memory byte address for the current write.
- `instruction`  out  32  — assembled instruction word.
- `load_we`  out  1  — one-cycle write strobe for `address`/`instruction`.
- `start`  out  1  — pipeline run enable, held high in RUN.
- `word_count`  out  $clog2(MAX_WORDS+1)  — words written in the current load.
- `busy`  out  1  — high in LOAD and ARM.
- `error`  out  1  — sticky overflow flag, cleared by `load_req` or `rst`.

## Operation
- States: IDLE, LOAD, ARM, RUN, ERR.
- Reset values: state IDLE; `rx_ready`, `load_we`, `start`, `busy`, `error` all 0; `address`, `instruction`, `word_count` all 0; byte index 0.
- IDLE, RUN, or ERR + `load_req` → LOAD. On this transition: `word_count`, byte index, and `error` clear, and `start` drops.
- LOAD, `rx_ready`=1:
  - Handshake occurs when `rx_valid`&`rx_ready`.
  - The byte goes to lane [8*idx+7:8*idx], then idx increments mod 4.
- Word completion occurs on a handshake with idx==3, or on a handshake with `rx_last`=1 at any idx. On `rx_last`, unfilled upper lanes are zero.
- On completion with `word_count`<MAX_WORDS:
  - Next cycle: `instruction`=word, `address`=BASE_ADDR+4*`word_count` (pre-increment), `load_we`=1.
  - `word_count` increments in that same cycle.
- On completion with `word_count`==MAX_WORDS: no write, `error`=1, state ERR, `rx_ready`=0.
- Handshake with `rx_last` (no overflow) → ARM, and `rx_ready` drops the next cycle.
- ARM: counts START_DELAY cycles, then RUN. With START_DELAY=0, RUN follows ARM after one cycle.
- RUN: `start`=1, `rx_ready`=0; stays until `load_req` or `rst`.
- ERR: `start`=0 and `rx_ready`=0 until `load_req`.
- `load_req` in LOAD or ARM restarts: count, idx, and the partial word clear, and the state stays/returns to LOAD. A byte handshake in the same cycle as `load_req` is discarded. `load_req` takes priority.
- `address`/`instruction` hold their last written values between strobes.
- `rst` mid-load: immediate return to reset values; the partial word is lost.

## Timing
- `rx_ready` is registered: it rises the cycle after `load_req` and falls the cycle after the `rx_last` handshake or the overflow handshake.
- Byte acceptance is one byte per cycle when `rx_valid` is held high.
- Write latency: `load_we` is high exactly 1 cycle after the completing handshake, for 1 cycle.
- Start latency: `start` rises START_DELAY+1 cycles after the final `load_we` cycle. The ARM dwell is START_DELAY+1 cycles, counted from the final `load_we` cycle.
- `start` falls the cycle after `load_req`.
- Outputs are registered; no combinational path from `rx_valid` to `rx_ready`.

## Test plan
- Reset values: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; after release, `rx_ready`=0 until `load_req`.
- Single word load:
  - Stimulus: `load_req`, then bytes 13,00,00,00 back-to-back with `rx_last` on the 4th.
  - Required: `load_we` pulse with `address`=0, `instruction`=32'h0000_0013, `word_count`=1.
  - Required (START_DELAY=2): `start`=1 exactly 3 cycles after the `load_we` cycle.
- Partial last word: 6 bytes EF,BE,AD,DE,34,12 → writes 32'hDEAD_BEEF @0, then 32'h0000_1234 @4.
- Back-pressure gaps: `rx_valid` toggled every other cycle across 8 bytes → two writes with correct addresses 0 and 4; no byte duplicated or lost.
- Overflow: MAX_WORDS=2, send 12 bytes → writes @0 and @4 only; `error`=1; state ERR; `start` stays 0.
  - Then `load_req` → `error`=0, `rx_ready`=1.
- Reload from RUN: while `start`=1, pulse `load_req` → `start`=0 next cycle; `word_count`=0; a new program loads from BASE_ADDR.
- Restart during LOAD: `load_req` after 2 bytes, coincident with a 3rd handshake → the 3rd byte is discarded, and the next 4 bytes form the word at BASE_ADDR.
